modulator_scheduler: RTL
========================

Name: modulator_scheduler

Overview:
- Sequences packets from two bit-stream sources into the single modulator input pair (valid, bit_in), running in the clk_slow domain.
- Arbitrates round-robin between sources and prepends a fixed preamble to each packet.
- Pads odd-length payloads so every packet is a whole number of 2-bit groups.
- Guarantees a valid-low gap of at least GAP cycles between packets, which the modulator requires (>=3 slow cycles).

Parameters:
LEN_W, 8, payload length width in bits (max payload 2^LEN_W-1 bits)
PRE_LEN, 6, preamble length in bits; must be even and >=2
PREAMBLE, 6'b110011, preamble pattern, sent MSB first
GAP, 3, valid-low cycles between packets; must be >=3

Ports:
clk  in  1  slow clock, same net as modulator clk_slow
rst  in  1  reset, synchronous, active-high
req  in  2  req[i]: source i has a packet pending; held until grant[i]
len0  in  LEN_W  source 0 payload length; stable while req[0]=1
len1  in  LEN_W  source 1 payload length; stable while req[1]=1
bit0  in  1  source 0 current payload bit (show-ahead)
bit1  in  1  source 1 current payload bit (show-ahead)
grant  out  2  one-cycle pulse; source i's packet accepted, source drops or renews req
bit_rd  out  2  bit_rd[i]=1: bit_i is consumed at this edge; source advances to its next bit
valid  out  1  to modulator valid
bit_out  out  1  to modulator bit_in
busy  out  1  state != IDLE
cur_src  out  1  source being sent; holds last value when idle

Behaviour:
- Reset values: state IDLE, valid=0, bit_out=0, grant=0, bit_rd=0, busy=0, cur_src=0, rr pointer=0 (source 0 preferred).
- Reset mid-packet: abort immediately with no pad or gap. Sources must also be reset.
- States: IDLE, PRE, DATA, PAD, GAP.
- All outputs are registered except bit_rd, which is decoded from state and cur_src.
- Arbitration: evaluated in IDLE and in the last GAP cycle.
  - One requester: grant it.
  - Both requesting: grant the source not granted last time.
  - The rr pointer updates only on grant.
- Grant edge: len of the winner is latched, cur_src is set, and grant[winner]=1 for the next cycle.
  - len!=0: the same edge enters PRE with valid<=1 and bit_out<=PREAMBLE[PRE_LEN-1].
  - len==0: packet dropped; grant is still pulsed, valid stays 0, state returns to IDLE (no GAP).
- Output stream per packet: valid high for exactly PRE_LEN+len+(len odd) consecutive cycles, starting in the grant cycle.
  - Order: preamble MSB..LSB, then payload in read order, then a single 0 if len is odd.
- bit_rd[cur_src] timing:
  - High in the cycle that shows the last preamble bit, and in each DATA cycle except the one showing the final payload bit.
  - Exactly len pulses in total.
  - bit_out equals the sampled bit_i one cycle after each pulse.
  - bit_rd of the non-selected source is always 0.
- Counters: payload counter of LEN_W bits, loaded with len and decremented per bit_rd. The last read happens when count==1. No wrap, since the counter is never decremented at 0.
- PAD: entered after the final payload bit when len is odd; one cycle with valid=1, bit_out=0.
- GAP: valid=0 and bit_out=0 for exactly GAP cycles.
  - Back-to-back requests therefore see exactly GAP idle cycles.
  - The next grant edge is the end of the last GAP cycle.
- req rules:
  - req changes during PRE/DATA/PAD/GAP are ignored except for arbitration.
  - A req deasserted before grant is legal and withdraws the request.
  - Both req low at the last GAP cycle: go to IDLE.
- Simultaneous req rise with an in-flight packet: no preemption.

Decomposition:
- Shared package modem_pkg holds:
  - state enum (IDLE, PRE, DATA, PAD, GAP)
  - default PREAMBLE and PRE_LEN
  - MIN_GAP=3
  - elaboration checks: GAP>=MIN_GAP, PRE_LEN even
- One sub-module, rr_arbiter2: 2-way round-robin with registered pointer and update-on-grant input.
- FSM, counters and output registers stay in modulator_scheduler.

Test Plan:
- req=01, len0=4, bits 1,0,1,1 -> grant=01 pulse; valid high 10 cycles; bit_out 1,1,0,0,1,1,1,0,1,1; 4 bit_rd[0] pulses; then valid=0 for 3 cycles; busy falls.
- req=10, len1=3, bits 1,1,1 -> valid high 10 cycles; payload 1,1,1 then pad 0; bit_rd[1] pulses exactly 3.
- req=11 held, len0=len1=2 -> grant order 01,10,01,...; consecutive packets separated by exactly 3 valid-low cycles; cur_src alternates.
- req=01 with len0=0, req=10 with len1=2 one cycle later -> grant[0] pulse with no valid; source 1 then sent normally; no gap inserted after the dropped packet.
- rst=1 for 1 cycle during DATA of a len=8 packet -> next cycle valid=0, grant=0, bit_rd=0, busy=0; a new req=11 then grants source 0 first.
- Source toggles bit0 every cycle, len0=6 -> payload on bit_out matches bit0 values sampled at each bit_rd edge, delayed by one cycle.

Source files
------------

// File: rtl/modem_pkg.sv
// Shared types and constants for the modulator-side packet scheduler.
// Holds the scheduler state encoding, default preamble and parameter sanity checks.
package modem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAD,
    S_GAP
  } sched_state_t;

  localparam int DEF_PRE_LEN = 6;
  localparam logic [DEF_PRE_LEN-1:0] DEF_PREAMBLE = 6'b110011;

  // The modulator needs at least this many valid-low slow cycles between packets
  localparam int MIN_GAP = 3;

  function automatic bit gap_ok(input int gap);
    return gap >= MIN_GAP;
  endfunction

  function automatic bit pre_len_ok(input int pre_len);
    return (pre_len >= 2) && ((pre_len % 2) == 0);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer names the preferred source on a tie
// and moves to the other source whenever a grant is actually taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt,
  output logic       win
);

  logic ptr;

  always_comb begin
    win = ptr;
    if (req == 2'b01) begin
      win = 1'b0;
    end else if (req == 2'b10) begin
      win = 1'b1;
    end
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = win ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update && (req != 2'b00)) begin
      ptr <= ~win;
    end
  end

endmodule

// File: rtl/modulator_scheduler.sv
// Packet scheduler feeding the modulator: round-robin between two bit sources,
// preamble insertion, odd-length padding and a guaranteed inter-packet gap.
module modulator_scheduler
  import modem_pkg::*;
#(
  parameter int                 LEN_W    = 8,
  parameter int                 PRE_LEN  = DEF_PRE_LEN,
  parameter logic [PRE_LEN-1:0] PREAMBLE = DEF_PREAMBLE,
  parameter int                 GAP      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             bit0,
  input  logic             bit1,
  output logic [1:0]       grant,
  output logic [1:0]       bit_rd,
  output logic             valid,
  output logic             bit_out,
  output logic             busy,
  output logic             cur_src
);

  localparam int PRE_CNT_W = $clog2(PRE_LEN + 1);
  localparam int GAP_CNT_W = $clog2(GAP + 1);
  localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRE_LEN);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP);

  if (!gap_ok(GAP)) begin : g_gap_check
    $error("modulator_scheduler: GAP must be at least %0d", MIN_GAP);
  end
  if (!pre_len_ok(PRE_LEN)) begin : g_pre_check
    $error("modulator_scheduler: PRE_LEN must be even and at least 2");
  end

  sched_state_t         state;
  logic [LEN_W-1:0]     len_cnt;
  logic                 odd_len;
  logic [PRE_LEN-1:0]   pre_sr;
  logic [PRE_CNT_W-1:0] pre_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;

  logic                 arb_en;
  logic                 take;
  logic [1:0]           arb_gnt;
  logic                 arb_win;
  logic [LEN_W-1:0]     win_len;
  logic                 sel_bit;
  logic                 rd_any;

  assign arb_en  = (state == S_IDLE) || ((state == S_GAP) && (gap_cnt == GAP_LAST));
  assign take    = arb_en && (req != 2'b00);
  assign win_len = arb_win ? len1 : len0;
  assign sel_bit = cur_src ? bit1 : bit0;

  // A read is issued one cycle ahead of display, so the final payload bit needs no read
  assign rd_any  = ((state == S_PRE) && (pre_cnt == PRE_LAST)) ||
                   ((state == S_DATA) && (len_cnt != '0));
  assign bit_rd  = {rd_any & cur_src, rd_any & ~cur_src};

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (take),
    .gnt    (arb_gnt),
    .win    (arb_win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      valid   <= 1'b0;
      bit_out <= 1'b0;
      grant   <= 2'b00;
      busy    <= 1'b0;
      cur_src <= 1'b0;
      len_cnt <= '0;
      odd_len <= 1'b0;
      pre_sr  <= '0;
      pre_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      grant <= 2'b00;
      case (state)
        S_PRE: begin
          if (pre_cnt == PRE_LAST) begin
            bit_out <= sel_bit;
            len_cnt <= len_cnt - 1'b1;
            state   <= S_DATA;
          end else begin
            bit_out <= pre_sr[PRE_LEN-1];
            pre_sr  <= pre_sr << 1;
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (len_cnt != '0) begin
            bit_out <= sel_bit;
            len_cnt <= len_cnt - 1'b1;
          end else if (odd_len) begin
            bit_out <= 1'b0;
            state   <= S_PAD;
          end else begin
            valid   <= 1'b0;
            bit_out <= 1'b0;
            gap_cnt <= GAP_CNT_W'(1);
            state   <= S_GAP;
          end
        end
        S_PAD: begin
          valid   <= 1'b0;
          bit_out <= 1'b0;
          gap_cnt <= GAP_CNT_W'(1);
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (!take) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
        end
      endcase

      // A zero-length winner is acknowledged but never reaches the modulator
      if (take) begin
        grant   <= arb_gnt;
        cur_src <= arb_win;
        len_cnt <= win_len;
        odd_len <= win_len[0];
        pre_sr  <= PREAMBLE << 1;
        pre_cnt <= PRE_CNT_W'(1);
        if (win_len != '0) begin
          state   <= S_PRE;
          valid   <= 1'b1;
          bit_out <= PREAMBLE[PRE_LEN-1];
          busy    <= 1'b1;
        end else begin
          state   <= S_IDLE;
          valid   <= 1'b0;
          bit_out <= 1'b0;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule
